core_run_controller: RTL and testbench

- Sequences one RISC_V_Core run: holds the core in reset, pulses start with the program address, waits for halt, then pulses report.
- Sits between the host/loader command interface and the core's clock/reset/start/prog_address/report pins; one instance per core.
- Returns completion status and a run-cycle count to the host.

---
 rtl/core_ctrl_pkg.sv | 16 +
 rtl/run_cycle_counter.sv | 34 +++
 rtl/core_run_controller.sv | 179 +++++++++++++++++
 tb/tb_core_run_controller.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state encoding and completion status codes for the core run controller
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_HOLD = 3'd1,
        S_START    = 3'd2,
        S_RUN      = 3'd3,
        S_REPORT   = 3'd4
    } state_e;

    localparam logic [1:0] ST_HALTED  = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORTED = 2'b10;

endpackage

// File: rtl/run_cycle_counter.sv
// rtl/run_cycle_counter.sv - saturating up-counter with synchronous clear and count enable
module run_cycle_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/core_run_controller.sv
// rtl/core_run_controller.sv - sequences one core run (reset hold, start, run, report); CORE_RUN_WATCHDOG_EN adds a RUN timeout
module core_run_controller
    import core_ctrl_pkg::*;
#(
    parameter int ADDRESS_BITS   = 20,
    parameter int RESET_CYCLES   = 2,
    parameter int COUNT_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDRESS_BITS-1:0] cmd_addr,
    input  logic                    abort,
    input  logic                    core_halt,
    output logic                    core_reset,
    output logic                    core_start,
    output logic [ADDRESS_BITS-1:0] core_prog_address,
    output logic                    core_report,
    output logic                    busy,
    output logic                    done_valid,
    output logic [1:0]              done_status,
    output logic [COUNT_WIDTH-1:0]  run_cycles
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [1:0]              status_q, status_d;
    logic                    core_reset_q, core_reset_d;
    logic                    core_start_q, core_start_d;
    logic                    report_q, report_d;
    logic                    busy_q, busy_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    cnt_clr;
    logic                    cnt_en;
    logic                    timeout_hit;

`ifdef CORE_RUN_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    // Loaded while in START so RUN cycle k sees TIMEOUT_CYCLES-k; zero marks the last allowed cycle.
    always_comb begin
        wd_d = wd_q;
        if (state_q == S_START) begin
            wd_d = WD_W'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == S_RUN) && (wd_q != '0)) begin
            wd_d = wd_q - WD_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout_hit = (state_q == S_RUN) && (wd_q == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        addr_d   = addr_q;
        status_d = status_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d   = cmd_addr;
                    status_d = ST_HALTED;
                    cnt_clr  = 1'b1;
                    hold_d   = HOLD_LOAD;
                    state_d  = S_RST_HOLD;
                end
            end
            S_RST_HOLD: begin
                if (abort) begin
                    status_d = ST_ABORTED;
                    state_d  = S_REPORT;
                end else if (hold_q == '0) begin
                    state_d = S_START;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_START: begin
                if (abort) begin
                    status_d = ST_ABORTED;
                    state_d  = S_REPORT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // The exit cycle itself is counted, so halt at RUN cycle N reports N.
                cnt_en = 1'b1;
                if (core_halt) begin
                    status_d = ST_HALTED;
                    state_d  = S_REPORT;
                end else if (abort) begin
                    status_d = ST_ABORTED;
                    state_d  = S_REPORT;
                end else if (timeout_hit) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_REPORT;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pin values are decoded from the next state so every output leaves a flop.
        core_reset_d = (state_d == S_IDLE) || (state_d == S_RST_HOLD);
        core_start_d = (state_d == S_START);
        report_d     = (state_d == S_REPORT);
        busy_d       = (state_d != S_IDLE);
        cmd_ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            addr_q       <= '0;
            status_q     <= ST_HALTED;
            core_reset_q <= 1'b1;
            core_start_q <= 1'b0;
            report_q     <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            addr_q       <= addr_d;
            status_q     <= status_d;
            core_reset_q <= core_reset_d;
            core_start_q <= core_start_d;
            report_q     <= report_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    run_cycle_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_run_cycle_counter (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (run_cycles)
    );

    assign cmd_ready         = cmd_ready_q;
    assign busy              = busy_q;
    assign core_reset        = core_reset_q;
    assign core_start        = core_start_q;
    assign core_report       = report_q;
    assign done_valid        = report_q;
    assign done_status       = status_q;
    assign core_prog_address = addr_q;

endmodule

// File: tb/tb_core_run_controller.sv
// tb/tb_core_run_controller.sv - randomized self-checking bench for core_run_controller against a run-level reference model
module tb_core_run_controller;

    localparam int AB = 20;
    localparam int R  = 2;
    localparam int T  = 50;
    localparam int S  = R + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AB-1:0] cmd_addr = '0;
    logic          abort = 1'b0;
    logic          core_halt = 1'b0;
    logic          core_reset;
    logic          core_start;
    logic [AB-1:0] core_prog_address;
    logic          core_report;
    logic          busy;
    logic          done_valid;
    logic [1:0]    done_status;
    logic [31:0]   run_cycles;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    core_run_controller #(
        .ADDRESS_BITS   (AB),
        .RESET_CYCLES   (R),
        .COUNT_WIDTH    (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_addr          (cmd_addr),
        .abort             (abort),
        .core_halt         (core_halt),
        .core_reset        (core_reset),
        .core_start        (core_start),
        .core_prog_address (core_prog_address),
        .core_report       (core_report),
        .busy              (busy),
        .done_valid        (done_valid),
        .done_status       (done_status),
        .run_cycles        (run_cycles)
    );

`ifdef CORE_RUN_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    // Observations from one run; cycle 0 is the cycle cmd_valid is offered.
    logic          obs_acc;
    int            obs_start_cyc, obs_start_cnt, obs_hold, obs_done_cyc, obs_done_cnt, obs_bad;
    logic [1:0]    obs_status;
    logic [31:0]   obs_rc;
    logic [AB-1:0] obs_addr;
    logic          obs_idle_after;

    int exp_start_cyc, exp_done_cyc, exp_status, exp_rc, exp_hold, exp_start_cnt;

    // Reference: a run ends at the earliest of halt/abort/timeout (ties resolve halt > abort > timeout).
    task automatic model_run(input int hc, input int ab);
        int end_k;
        int st;
        if (ab >= 1 && ab <= R) begin
            exp_start_cyc = -1; exp_start_cnt = 0; exp_done_cyc = ab + 1;
            exp_status = 2; exp_rc = 0; exp_hold = ab;
            return;
        end
        end_k = 1 << 30;
        st = -1;
        if (WD) begin end_k = T; st = 1; end
        if (ab > S && ab - S <= end_k) begin end_k = ab - S; st = 2; end
        if (hc > S && hc - S <= end_k) begin end_k = hc - S; st = 0; end
        exp_start_cyc = S; exp_start_cnt = 1; exp_hold = R;
        exp_status = (st < 0) ? 0 : st;
        exp_rc = (st < 0) ? 0 : end_k;
        exp_done_cyc = (st < 0) ? -1 : S + end_k + 1;
    endtask

    task automatic run_cmd(input logic [AB-1:0] addr, input int hc, input int ab, input int max_cyc);
        obs_acc = 1'b0; obs_start_cyc = -1; obs_start_cnt = 0; obs_hold = 0;
        obs_done_cyc = -1; obs_done_cnt = 0; obs_bad = 0; obs_status = 2'b11;
        obs_rc = 32'hdead_beef; obs_addr = '1; obs_idle_after = 1'b0;
        @(negedge clock);
        for (int c = 0; c < max_cyc; c++) begin
            cmd_valid = (c == 0);
            cmd_addr  = addr;
            core_halt = (c == hc);
            abort     = (c == ab);
            #1;
            if (c == 0) obs_acc = cmd_ready;
            if (core_start) begin
                obs_start_cnt++;
                if (obs_start_cyc < 0) obs_start_cyc = c;
            end
            if (c >= 1 && obs_done_cyc < 0 && core_reset) obs_hold++;
            if (done_valid) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = c; obs_status = done_status;
                    obs_rc = run_cycles; obs_addr = core_prog_address;
                end
            end
            if (core_report !== done_valid || busy !== !cmd_ready) obs_bad++;
            if (obs_done_cyc >= 0 && c == obs_done_cyc + 1) begin
                obs_idle_after = cmd_ready && core_reset && !busy && !done_valid;
                break;
            end
            @(negedge clock);
        end
        cmd_valid = 1'b0; core_halt = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        vectors++;
        if ({core_reset, core_start, core_report, done_valid, busy, cmd_ready} !== 6'b100001) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 100001", {core_reset, core_start, core_report, done_valid, busy, cmd_ready});
        end
        vectors++;
        if ({core_prog_address, done_status, run_cycles} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got addr=%h st=%b rc=%0d want all zero", core_prog_address, done_status, run_cycles);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic_halt;
        run_cmd(20'h00100, S + 10, -1, 40);
        model_run(S + 10, -1);
        vectors++;
        if (obs_acc !== 1'b1) begin miscompares++; $display("FAIL basic accept: got %b want 1", obs_acc); end
        vectors++;
        if (obs_hold !== exp_hold) begin miscompares++; $display("FAIL basic hold: got %0d want %0d", obs_hold, exp_hold); end
        vectors++;
        if (obs_start_cyc !== exp_start_cyc || obs_start_cnt !== 1) begin
            miscompares++; $display("FAIL basic start: got cyc=%0d cnt=%0d want cyc=%0d cnt=1", obs_start_cyc, obs_start_cnt, exp_start_cyc);
        end
        vectors++;
        if (obs_done_cyc !== exp_done_cyc || obs_done_cnt !== 1) begin
            miscompares++; $display("FAIL basic done: got cyc=%0d cnt=%0d want cyc=%0d cnt=1", obs_done_cyc, obs_done_cnt, exp_done_cyc);
        end
        vectors++;
        if (obs_status !== 2'(exp_status) || obs_rc !== 32'(exp_rc) || obs_addr !== 20'h00100) begin
            miscompares++; $display("FAIL basic result: got st=%0d rc=%0d addr=%h want st=%0d rc=%0d addr=00100", obs_status, obs_rc, obs_addr, exp_status, exp_rc);
        end
        vectors++;
        if (obs_bad !== 0 || obs_idle_after !== 1'b1) begin
            miscompares++; $display("FAIL basic flags: got bad=%0d idle_after=%b want 0/1", obs_bad, obs_idle_after);
        end
    endtask

    task automatic test_random_runs;
        for (int i = 0; i < 24; i++) begin
            logic [AB-1:0] a;
            int hc, ab, kind;
            a = AB'($urandom);
            hc = S + int'($urandom_range(1, 40));
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: ab = -1;
                1: ab = int'($urandom_range(1, R));
                default: ab = S + int'($urandom_range(1, 40));
            endcase
            if (kind == 2) hc = ab;
            run_cmd(a, hc, ab, 80);
            model_run(hc, ab);
            vectors++;
            if (obs_start_cyc !== exp_start_cyc || obs_start_cnt !== exp_start_cnt || obs_hold !== exp_hold) begin
                miscompares++;
                $display("FAIL rand%0d seq: got start=%0d/%0d hold=%0d want start=%0d/%0d hold=%0d", i, obs_start_cyc, obs_start_cnt, obs_hold, exp_start_cyc, exp_start_cnt, exp_hold);
            end
            vectors++;
            if (obs_done_cyc !== exp_done_cyc || obs_status !== 2'(exp_status) || obs_rc !== 32'(exp_rc) || obs_addr !== a) begin
                miscompares++;
                $display("FAIL rand%0d result: got done=%0d st=%0d rc=%0d addr=%h want done=%0d st=%0d rc=%0d addr=%h", i, obs_done_cyc, obs_status, obs_rc, obs_addr, exp_done_cyc, exp_status, exp_rc, a);
            end
            vectors++;
            if (obs_done_cnt !== 1 || obs_bad !== 0 || obs_idle_after !== 1'b1) begin
                miscompares++;
                $display("FAIL rand%0d flags: got dcnt=%0d bad=%0d idle=%b want 1/0/1", i, obs_done_cnt, obs_bad, obs_idle_after);
            end
        end
    endtask

    task automatic test_abort_hold;
        for (int ab = 1; ab <= R; ab++) begin
            run_cmd(20'h0abcd, -1, ab, 20);
            vectors++;
            if (obs_start_cnt !== 0 || obs_done_cnt !== 1 || obs_status !== 2'b10 || obs_rc !== 32'd0 || obs_done_cyc !== ab + 1) begin
                miscompares++;
                $display("FAIL abort_hold%0d: got starts=%0d dcnt=%0d st=%b rc=%0d done=%0d want 0/1/10/0/%0d", ab, obs_start_cnt, obs_done_cnt, obs_status, obs_rc, obs_done_cyc, ab + 1);
            end
        end
    endtask

    task automatic test_abort_run;
        run_cmd(20'h12345, -1, S + 5, 30);
        vectors++;
        if (obs_status !== 2'b10 || obs_rc !== 32'd5 || obs_start_cnt !== 1 || obs_done_cyc !== S + 6) begin
            miscompares++;
            $display("FAIL abort_run: got st=%b rc=%0d starts=%0d done=%0d want 10/5/1/%0d", obs_status, obs_rc, obs_start_cnt, obs_done_cyc, S + 6);
        end
    endtask

    task automatic test_halt_abort_same;
        run_cmd(20'h00042, S + 7, S + 7, 30);
        vectors++;
        if (obs_status !== 2'b00 || obs_rc !== 32'd7) begin
            miscompares++; $display("FAIL halt_abort_same: got st=%b rc=%0d want 00/7", obs_status, obs_rc);
        end
    endtask

    task automatic test_halt_idle_ignored;
        @(negedge clock);
        core_halt = 1'b1; abort = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        vectors++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || done_valid !== 1'b0 || core_start !== 1'b0) begin
            miscompares++; $display("FAIL idle_ignore: got busy=%b rdy=%b dv=%b st=%b want 0/1/0/0", busy, cmd_ready, done_valid, core_start);
        end
        core_halt = 1'b0; abort = 1'b0;
    endtask

    task automatic test_back_to_back;
        int acc_c[2], st_c[2], dn_c[2];
        int na, ns, nd, d1, halt2;
        na = 0; ns = 0; nd = 0;
        d1 = S + 7;
        halt2 = d1 + 1 + S + 6;
        @(negedge clock);
        for (int c = 0; c < 40; c++) begin
            cmd_valid = (na < 2);
            cmd_addr  = (na == 0) ? 20'haaaaa : 20'h55555;
            core_halt = (c == S + 6) || (c == halt2);
            #1;
            if (cmd_valid && cmd_ready) begin
                if (na < 2) acc_c[na] = c;
                na++;
            end
            if (core_start) begin
                if (ns < 2) st_c[ns] = c;
                ns++;
            end
            if (done_valid) begin
                if (nd < 2) dn_c[nd] = c;
                nd++;
                if (nd == 2) obs_addr = core_prog_address;
                if (run_cycles !== 32'd6) obs_bad = 99;
            end
            @(negedge clock);
        end
        cmd_valid = 1'b0; core_halt = 1'b0;
        vectors++;
        if (na !== 2 || ns !== 2 || nd !== 2) begin
            miscompares++; $display("FAIL b2b counts: got acc=%0d starts=%0d dones=%0d want 2/2/2", na, ns, nd);
        end else begin
            vectors++;
            if (acc_c[0] !== 0 || acc_c[1] !== d1 + 1) begin
                miscompares++; $display("FAIL b2b accept: got %0d,%0d want 0,%0d", acc_c[0], acc_c[1], d1 + 1);
            end
            vectors++;
            if (st_c[0] !== S || st_c[1] !== d1 + 1 + S || dn_c[0] !== d1 || dn_c[1] !== halt2 + 1) begin
                miscompares++;
                $display("FAIL b2b timing: got st=%0d,%0d dn=%0d,%0d want st=%0d,%0d dn=%0d,%0d", st_c[0], st_c[1], dn_c[0], dn_c[1], S, d1 + 1 + S, d1, halt2 + 1);
            end
            vectors++;
            if (obs_addr !== 20'h55555 || obs_bad === 99) begin
                miscompares++; $display("FAIL b2b result: got addr=%h rc_bad=%0d want 55555 with rc 6", obs_addr, obs_bad);
            end
        end
    endtask

    task automatic test_watchdog;
`ifdef CORE_RUN_WATCHDOG_EN
        run_cmd(20'h0beef, -1, -1, 100);
        model_run(-1, -1);
        vectors++;
        if (obs_status !== 2'(exp_status) || obs_rc !== 32'(exp_rc) || obs_done_cyc !== exp_done_cyc) begin
            miscompares++;
            $display("FAIL watchdog: got st=%b rc=%0d done=%0d want st=%0d rc=%0d done=%0d", obs_status, obs_rc, obs_done_cyc, exp_status, exp_rc, exp_done_cyc);
        end
`else
        run_cmd(20'h0beef, -1, -1, 1000);
        #1;
        vectors++;
        if (obs_done_cnt !== 0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL no_watchdog busy: got dones=%0d busy=%b want 0/1", obs_done_cnt, busy);
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        #1;
        vectors++;
        if (done_valid !== 1'b1 || done_status !== 2'b10 || run_cycles !== 32'(1000 - S)) begin
            miscompares++;
            $display("FAIL no_watchdog abort: got dv=%b st=%b rc=%0d want 1/10/%0d", done_valid, done_status, run_cycles, 1000 - S);
        end
        repeat (2) @(negedge clock);
`endif
    endtask

    task automatic test_reset_mid_run;
        int seen_done;
        seen_done = 0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_addr = 20'h0f0f0;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (S + 3) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({core_reset, core_start, core_report, done_valid, busy, cmd_ready} !== 6'b100001
            || {core_prog_address, done_status, run_cycles} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_run: got ctrl=%b addr=%h st=%b rc=%0d want 100001/0/0/0", {core_reset, core_start, core_report, done_valid, busy, cmd_ready}, core_prog_address, done_status, run_cycles);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clock); #1;
            if (done_valid) seen_done++;
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock); #1;
            if (done_valid) seen_done++;
        end
        vectors++;
        if (seen_done !== 0) begin miscompares++; $display("FAIL reset_no_done: got %0d pulses want 0", seen_done); end
        run_cmd(20'h00777, S + 3, -1, 30);
        vectors++;
        if (obs_status !== 2'b00 || obs_rc !== 32'd3 || obs_addr !== 20'h00777 || obs_done_cyc !== S + 4) begin
            miscompares++;
            $display("FAIL reset_fresh_run: got st=%b rc=%0d addr=%h done=%0d want 00/3/00777/%0d", obs_status, obs_rc, obs_addr, obs_done_cyc, S + 4);
        end
    endtask

    initial begin
        test_reset();
        test_basic_halt();
        test_random_runs();
        test_abort_hold();
        test_abort_run();
        test_halt_abort_same();
        test_halt_idle_ignored();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
